// File: rtl/link_pkg.sv
// Shared definitions for the 9-bit-word serial link (transmit and receive).
//   WORD_W     : bits per line word, {k, byte[7:0]}, sent MSB (k) first
//   COMMA      : K-coded alignment byte
//   KCODE      : value of the k bit on control words
//   COMMA_WORD : full 9-bit comma word, 9'h13C
//   rx_state_e : receive alignment states
package link_pkg;

  localparam int unsigned         WORD_W     = 9;
  localparam logic [7:0]          COMMA      = 8'h3C;
  localparam logic                KCODE      = 1'b1;
  localparam logic [WORD_W-1:0]   COMMA_WORD = {KCODE, COMMA};

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC,
    ST_LOCK
  } rx_state_e;

  function automatic logic is_comma(input logic [WORD_W-1:0] word);
    return word == COMMA_WORD;
  endfunction

endpackage

// File: rtl/rx_serial.sv
// Serial front end of the link receiver: 9-bit shift register plus the bit
// counter that marks word boundaries.
//   clk_i     : system clock, one serial bit per cycle
//   rst_ni    : asynchronous active-low reset
//   data_i    : serial line, synchronous to clk_i
//   realign_i : restart the bit counter; the next bit is bit 0 of a word
//   word_o    : current shift-register contents (newest bit in [0])
//   ena_o     : high while word_o holds a complete, aligned word
//   comma_o   : high while word_o equals the comma word (any alignment)
module rx_serial
  import link_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              data_i,
  input  logic              realign_i,
  output logic [WORD_W-1:0] word_o,
  output logic              ena_o,
  output logic              comma_o
);

  localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

  logic [WORD_W-1:0] sh_q;
  logic [3:0]        cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q <= {sh_q[WORD_W-2:0], data_i};
      // cnt_q is the index of the newest bit within the current word, so a
      // realign makes the bit shifted in on this edge bit 0.
      if (realign_i || cnt_q == LAST_BIT) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + 4'd1;
    end
  end

  assign word_o  = sh_q;
  assign ena_o   = (cnt_q == LAST_BIT);
  assign comma_o = is_comma(sh_q);

endmodule

// File: rtl/deserializer_rx.sv
// Link receiver: hunts for the comma to find word alignment, confirms it over
// LOCK_FRAMES commas, then delivers each 3-byte payload as a 24-bit word.
//   LOCK_FRAMES : consecutive good commas needed before lock (1..15)
//   clk_i       : system clock, one serial bit per cycle
//   rst_ni      : asynchronous active-low reset
//   data_i      : serial line, synchronous to clk_i
//   data_o      : last payload {B2, B1, B0}; held until the next payload
//   valid_o     : one-cycle strobe, coincident with a new data_o
//   lock_o      : high while aligned and locked
//   err_o       : one-cycle strobe when lock is lost
module deserializer_rx
  import link_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_i,
  output logic [23:0] data_o,
  output logic        valid_o,
  output logic        lock_o,
  output logic        err_o
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_FRAMES);
  localparam logic [3:0] GOOD_MAX = 4'hF;

  logic [WORD_W-1:0] word;
  logic              word_ena;
  logic              comma;
  logic              realign;

  rx_state_e   state_q, state_d;
  logic [1:0]  slot_q,  slot_d;   // 0: comma expected, 1..3: B0..B2 expected
  logic [3:0]  good_q,  good_d;
  logic [7:0]  b0_q,    b0_d;
  logic [7:0]  b1_q,    b1_d;
  logic [23:0] data_q,  data_d;
  logic        valid_q, valid_d;
  logic        err_q,   err_d;
  logic        lock_q;

  rx_serial u_serial (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .data_i    (data_i),
    .realign_i (realign),
    .word_o    (word),
    .ena_o     (word_ena),
    .comma_o   (comma)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_HUNT;
      slot_q  <= '0;
      good_q  <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      good_q  <= good_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      lock_q  <= (state_d == ST_LOCK);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    slot_d  = slot_q;
    good_d  = good_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    realign = 1'b0;

    case (state_q)
      ST_HUNT: begin
        // Comma seen at an arbitrary bit position: adopt it as the boundary.
        if (comma) begin
          realign = 1'b1;
          slot_d  = 2'd1;
          good_d  = 4'd1;
          state_d = (LOCK_CNT == 4'd1) ? ST_LOCK : ST_SYNC;
        end
      end

      ST_SYNC, ST_LOCK: begin
        if (word_ena) begin
          if (is_comma(word)) begin
            // A comma on any boundary confirms alignment; in a data slot it
            // is idle fill and restarts payload capture at B0.
            slot_d = 2'd1;
            if (good_q != GOOD_MAX) good_d = good_q + 4'd1;
            if (state_q == ST_SYNC && good_d >= LOCK_CNT) state_d = ST_LOCK;
          end else if (slot_q == 2'd0 || word[WORD_W-1] == KCODE) begin
            state_d = ST_HUNT;
            err_d   = (state_q == ST_LOCK);
          end else begin
            case (slot_q)
              2'd1: begin
                b0_d   = word[WORD_W-2:0];
                slot_d = 2'd2;
              end
              2'd2: begin
                b1_d   = word[WORD_W-2:0];
                slot_d = 2'd3;
              end
              default: begin
                slot_d = 2'd0;
                if (state_q == ST_LOCK) begin
                  data_d  = {word[WORD_W-2:0], b1_q, b0_q};
                  valid_d = 1'b1;
                end
              end
            endcase
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign lock_o  = lock_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_deserializer_rx.sv
// Self-checking bench for deserializer_rx. A bit-level reference model turns
// every transmitted bit into expected events (payload strobes, error strobes,
// lock changes) tagged with the clock edge they must appear after; a monitor
// compares the DUT against those expectations on every falling edge.
module tb_deserializer_rx;

  localparam int          LF     = 2;
  localparam logic [8:0]  COMMA9 = 9'h13C;

  localparam int M_HUNT = 0;
  localparam int M_SYNC = 1;
  localparam int M_LOCK = 2;

  logic        clk;
  logic        rst_n;
  logic        data_i;
  logic [23:0] data_o;
  logic        valid_o;
  logic        lock_o;
  logic        err_o;

  deserializer_rx #(.LOCK_FRAMES(LF)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .lock_o  (lock_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          e;
    logic [23:0] d;
  } exp_t;

  exp_t vq[$];          // expected payload strobes
  int   eq[$];          // expected error strobes
  logic lock_at[int];   // expected lock level from a given edge onward

  // ---------------- reference model ----------------
  int          m_mode;
  logic [8:0]  m_win;     // last nine bits on the line
  int          m_pos;     // bits received since the current word began
  int          m_slot;    // 0 = comma expected, 1..3 = payload byte index + 1
  int          m_good;
  logic [7:0]  m_b0, m_b1;
  logic [23:0] m_data;    // value data_o should be holding

  task automatic model_reset();
    m_mode = M_HUNT;
    m_win  = '0;
    m_pos  = 0;
    m_slot = 0;
    m_good = 0;
    m_b0   = '0;
    m_b1   = '0;
    m_data = '0;
    lock_at.delete();
    lock_at[edge_cnt + 1] = 1'b0;
  endtask

  // Act on a complete aligned word; its effects are visible after edge e.
  task automatic model_word(input logic [8:0] w, input int e);
    if (w == COMMA9) begin
      m_slot = 1;
      m_good = (m_good < 15) ? m_good + 1 : 15;
      if (m_mode == M_SYNC && m_good >= LF) begin
        m_mode = M_LOCK;
        lock_at[e] = 1'b1;
      end
    end else if (m_slot == 0 || w[8]) begin
      if (m_mode == M_LOCK) begin
        eq.push_back(e);
        lock_at[e] = 1'b0;
      end
      m_mode = M_HUNT;
    end else begin
      if (m_slot == 1) m_b0 = w[7:0];
      if (m_slot == 2) m_b1 = w[7:0];
      if (m_slot == 3 && m_mode == M_LOCK) begin
        m_data = {w[7:0], m_b1, m_b0};
        vq.push_back('{e: e, d: m_data});
      end
      m_slot = (m_slot == 3) ? 0 : m_slot + 1;
    end
  endtask

  // Bit b is sampled by the DUT at edge k.
  task automatic model_bit(input logic b, input int k);
    m_win = {m_win[7:0], b};
    if (m_mode == M_HUNT) begin
      if (m_win == COMMA9) begin
        m_pos  = 0;
        m_slot = 1;
        m_good = 1;
        m_mode = (LF == 1) ? M_LOCK : M_SYNC;
        if (m_mode == M_LOCK) lock_at[k + 1] = 1'b1;
      end
    end else begin
      m_pos++;
      if (m_pos == 9) begin
        m_pos = 0;
        model_word(m_win, k + 1);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_bit(input logic b);
    @(negedge clk);
    data_i = b;
    if (rst_n) model_bit(b, edge_cnt + 1);
  endtask

  task automatic send_word(input logic [8:0] w);
    for (int i = 8; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_words(input logic [8:0] ws[$]);
    foreach (ws[i]) send_word(ws[i]);
  endtask

  function automatic logic [8:0] rand_data();
    logic [7:0] b;
    b = 8'($urandom);
    return {1'b0, b};
  endfunction

  function automatic logic [8:0] rand_bad_k();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h3C) b = 8'h3D;
    return {1'b1, b};
  endfunction

  // ---------------- monitor ----------------
  logic exp_lock = 1'b0;

  always @(negedge clk) begin
    if (lock_at.exists(edge_cnt)) exp_lock = lock_at[edge_cnt];
    if (rst_n) begin
      check("lock_o", lock_o, exp_lock);
      if (vq.size() > 0 && vq[0].e == edge_cnt) begin
        exp_t x;
        x = vq.pop_front();
        check("valid_o pulse", valid_o, 1'b1);
        check("data_o on valid", data_o, x.d);
      end else begin
        check("valid_o idle", valid_o, 1'b0);
      end
      if (eq.size() > 0 && eq[0] == edge_cnt) begin
        void'(eq.pop_front());
        check("err_o pulse", err_o, 1'b1);
      end else begin
        check("err_o idle", err_o, 1'b0);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [8:0] partial;

    rst_n  = 1'b0;
    data_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset data_o", data_o, 24'h0);
    check("reset valid_o", valid_o, 1'b0);
    check("reset lock_o", lock_o, 1'b0);
    check("reset err_o", err_o, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Misaligned start
    repeat (4) send_bit(1'($urandom));
    send_words('{COMMA9, COMMA9, 9'h011, 9'h022, 9'h033, COMMA9});
    check("misaligned data_o", data_o, 24'h332211);
    check("misaligned lock_o", lock_o, 1'b1);

    // Clean start sequence: idle commas then a frame
    send_words('{COMMA9, COMMA9, COMMA9});
    check("clean lock_o", lock_o, 1'b1);
    send_words('{COMMA9, 9'h0AA, 9'h055, 9'h0F0, COMMA9});
    check("clean data_o", data_o, 24'hF055AA);

    // Idle comma inside the data slots
    send_words('{COMMA9, 9'h0A1, COMMA9, 9'h0B1, 9'h0B2, 9'h0B3, COMMA9});
    check("idle-slot data_o", data_o, 24'hB3B2B1);

    // Bad K code in a data slot
    send_words('{COMMA9, 9'h0A1, 9'h1FC, 9'h000});
    check("bad-k lock_o", lock_o, 1'b0);
    check("bad-k data_o held", data_o, 24'hB3B2B1);
    send_words('{COMMA9, COMMA9, COMMA9});
    check("bad-k relock", lock_o, 1'b1);

    // Missing comma in slot 0
    send_words('{COMMA9, 9'h0C1, 9'h0C2, 9'h0C3, 9'h03C, 9'h000});
    check("missing-comma lock_o", lock_o, 1'b0);
    check("missing-comma data_o held", data_o, 24'hC3C2C1);
    send_words('{COMMA9, COMMA9, COMMA9});

    // Asynchronous reset in the middle of B1
    send_words('{COMMA9, 9'h0D1});
    partial = 9'h0D2;
    for (int i = 8; i >= 5; i--) send_bit(partial[i]);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async rst data_o", data_o, 24'h0);
    check("async rst valid_o", valid_o, 1'b0);
    check("async rst lock_o", lock_o, 1'b0);
    check("async rst err_o", err_o, 1'b0);
    repeat (3) send_bit(1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    send_words('{COMMA9, COMMA9, 9'h001, 9'h002, 9'h003, COMMA9});
    check("post-reset data_o", data_o, 24'h030201);

    // Randomised traffic with occasional corruption
    for (int f = 0; f < 150; f++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      send_word(COMMA9);
      if (r < 10) begin
        send_word(rand_data());
        send_word(rand_bad_k());
      end else if (r < 20) begin
        repeat (3) send_word(rand_data());
        send_word(9'h03C);
      end else if (r < 30) begin
        repeat ($urandom_range(1, 12)) send_bit(1'($urandom));
      end else begin
        for (int s = 0; s < 3; s++) begin
          if ($urandom_range(0, 9) == 0) send_word(COMMA9);
          send_word(rand_data());
        end
      end
    end

    // Flush: relock, one last frame, and let every expected event drain
    send_words('{COMMA9, COMMA9, COMMA9, COMMA9, 9'h0E1, 9'h0E2, 9'h0E3, COMMA9, COMMA9});
    check("final data_o", data_o, m_data);
    check("final lock_o", lock_o, 1'b1);
    check("pending valid events", vq.size(), 0);
    check("pending err events", eq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
